// File: rtl/uart_frame_buffer_ctrl.sv
// Frame-buffer sequencer: captures a UART frame into single-port RAM, lends the RAM
// to a host processor, then streams a TX region back out over UART.
module uart_frame_buffer_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned RX_LEN  = 65536,
    parameter int unsigned TX_LEN  = 16384,
    parameter int unsigned TX_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_byte,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              tx_go,
    input  logic              restart,
    output logic              load_done,
    output logic              send_done,
    output logic              busy_tx,
    output logic              rx_overrun
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RX_LAST   = ADDR_W'(RX_LEN - 1);
    localparam logic [ADDR_W-1:0] TX_LAST   = ADDR_W'(TX_LEN - 1);
    localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);

    typedef enum logic [2:0] {
        S_RX,
        S_HOST,
        S_TX_RD,
        S_TX_SEND,
        S_TX_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] rx_cnt, rx_cnt_nx;
    logic [ADDR_W-1:0] tx_cnt, tx_cnt_nx;
    logic              tx_start_nx;
    logic [DATA_W-1:0] tx_byte_nx;
    logic              overrun_nx;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [ADDR_W-1:0] tx_addr;

    // TX address wraps modulo the RAM depth by truncation
    assign tx_addr = TX_BASE_A + tx_cnt;

    always_comb begin
        state_nx    = state;
        rx_cnt_nx   = rx_cnt;
        tx_cnt_nx   = tx_cnt;
        tx_start_nx = 1'b0;
        tx_byte_nx  = tx_byte;
        overrun_nx  = rx_overrun;
        ram_we      = 1'b0;
        ram_addr    = host_addr;
        ram_wdata   = host_wdata;

        case (state)
            S_RX: begin
                ram_addr  = rx_cnt;
                ram_wdata = rx_byte;
                if (rx_valid) begin
                    ram_we = 1'b1;
                    if (rx_cnt == RX_LAST) begin
                        state_nx  = S_HOST;
                        rx_cnt_nx = '0;
                    end else begin
                        rx_cnt_nx = rx_cnt + 1'b1;
                    end
                end
            end
            S_HOST: begin
                ram_we = host_we;
                if (tx_go) begin
                    tx_cnt_nx = '0;
                    state_nx  = S_TX_RD;
                end
            end
            S_TX_RD: begin
                ram_addr = tx_addr;
                state_nx = S_TX_SEND;
            end
            S_TX_SEND: begin
                ram_addr    = tx_addr;
                tx_byte_nx  = ram_q;
                tx_start_nx = 1'b1;
                state_nx    = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                ram_addr = tx_addr;
                if (tx_done) begin
                    if (tx_cnt == TX_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        tx_cnt_nx = tx_cnt + 1'b1;
                        state_nx  = S_TX_RD;
                    end
                end
            end
            S_DONE: begin
                if (tx_go) begin
                    tx_cnt_nx = '0;
                    state_nx  = S_TX_RD;
                end
            end
            default: state_nx = S_RX;
        endcase

        if (rx_valid && (state != S_RX)) overrun_nx = 1'b1;

        // restart overrides everything, including a coincident rx_valid or tx_done
        if (restart) begin
            state_nx    = S_RX;
            rx_cnt_nx   = '0;
            tx_cnt_nx   = '0;
            tx_start_nx = 1'b0;
            overrun_nx  = 1'b0;
            ram_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RX;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
            tx_start   <= 1'b0;
            tx_byte    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            state      <= state_nx;
            rx_cnt     <= rx_cnt_nx;
            tx_cnt     <= tx_cnt_nx;
            tx_start   <= tx_start_nx;
            tx_byte    <= tx_byte_nx;
            rx_overrun <= overrun_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !rst) ram[ram_addr] <= ram_wdata;
        ram_q <= ram[ram_addr];
    end

    assign host_rdata = ram_q;
    assign load_done  = (state != S_RX);
    assign send_done  = (state == S_DONE);
    assign busy_tx    = (state == S_TX_RD) || (state == S_TX_SEND) || (state == S_TX_WAIT);

endmodule

// File: tb/tb_uart_frame_buffer_ctrl.sv
// Bench for uart_frame_buffer_ctrl: two instances (TX_BASE 12 and 14) share stimulus
// and are checked against a RAM-content model and per-instance captured TX streams.
module tb_uart_frame_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst, rx_valid, host_we, tx_go, restart;
    logic [7:0] rx_byte, host_wdata;
    logic [3:0] host_addr;

    logic       tx_done_a, tx_start_a, load_done_a, send_done_a, busy_tx_a, rx_overrun_a;
    logic       tx_done_b, tx_start_b, load_done_b, send_done_b, busy_tx_b, rx_overrun_b;
    logic [7:0] tx_byte_a, host_rdata_a, tx_byte_b, host_rdata_b;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem [16];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int         ua = 0;
    int         ub = 0;

    always #5 clk = ~clk;

    uart_frame_buffer_ctrl #(.DATA_W(8), .ADDR_W(4), .RX_LEN(8), .TX_LEN(4), .TX_BASE(12)) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_done(tx_done_a),
        .tx_start(tx_start_a), .tx_byte(tx_byte_a), .host_addr(host_addr), .host_we(host_we),
        .host_wdata(host_wdata), .host_rdata(host_rdata_a), .tx_go(tx_go), .restart(restart),
        .load_done(load_done_a), .send_done(send_done_a), .busy_tx(busy_tx_a),
        .rx_overrun(rx_overrun_a));

    uart_frame_buffer_ctrl #(.DATA_W(8), .ADDR_W(4), .RX_LEN(8), .TX_LEN(4), .TX_BASE(14)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_done(tx_done_b),
        .tx_start(tx_start_b), .tx_byte(tx_byte_b), .host_addr(host_addr), .host_we(host_we),
        .host_wdata(host_wdata), .host_rdata(host_rdata_b), .tx_go(tx_go), .restart(restart),
        .load_done(load_done_b), .send_done(send_done_b), .busy_tx(busy_tx_b),
        .rx_overrun(rx_overrun_b));

    // UART transmitter models: capture each started byte, answer tx_done ~5 cycles later
    assign tx_done_a = (ua == 1);
    assign tx_done_b = (ub == 1);

    always @(negedge clk) begin
        if (tx_start_a) begin
            qa.push_back(tx_byte_a);
            ua <= 6;
        end else if (ua > 0) begin
            ua <= ua - 1;
        end
        if (tx_start_b) begin
            qb.push_back(tx_byte_b);
            ub <= 6;
        end else if (ub > 0) begin
            ub <= ub - 1;
        end
        if (ua == 1 && qa.size() > 0) begin
            checks++;
            if (tx_byte_a !== qa[qa.size()-1]) begin
                failures++;
                $display("FAIL tx_byte_stable: got %h want %h", tx_byte_a, qa[qa.size()-1]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_go();
        tx_go = 1'b1;
        tick();
        tx_go = 1'b0;
    endtask

    task automatic rx_frame(input bit counting);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b = counting ? 8'(8'h10 + i) : 8'($urandom);
            if (i == 7) begin
                checks++;
                if ({load_done_a, load_done_b} !== 2'b00) begin
                    failures++;
                    $display("FAIL load_done_early: got %b want 00", {load_done_a, load_done_b});
                end
            end
            send_byte(b);
            mem[i] = b;
        end
        checks++;
        if ({load_done_a, load_done_b} !== 2'b11) begin
            failures++;
            $display("FAIL load_done_set: got %b want 11", {load_done_a, load_done_b});
        end
    endtask

    task automatic read_back(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            host_addr = 4'(i);
            tick();
            checks++;
            if (host_rdata_a !== mem[i] || host_rdata_b !== mem[i]) begin
                failures++;
                $display("FAIL host_read[%0d]: got %h/%h want %h", i, host_rdata_a, host_rdata_b, mem[i]);
            end
        end
    endtask

    task automatic wait_send_and_check(input string tag);
        int n = 0;
        while (!(send_done_a && send_done_b) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_timeout: got send_done=%b%b want 11", tag, send_done_a, send_done_b);
        end
        checks++;
        if ({busy_tx_a, busy_tx_b, load_done_a, load_done_b} !== 4'b0011) begin
            failures++;
            $display("FAIL %s_flags: got busy=%b%b load=%b%b want busy=00 load=11", tag,
                     busy_tx_a, busy_tx_b, load_done_a, load_done_b);
        end
        checks++;
        if (qa.size() != 4 || qb.size() != 4) begin
            failures++;
            $display("FAIL %s_count: got %0d/%0d want 4", tag, qa.size(), qb.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (qa[i] !== mem[(12 + i) % 16] || qb[i] !== mem[(14 + i) % 16]) begin
                    failures++;
                    $display("FAIL %s_byte[%0d]: got %h/%h want %h/%h", tag, i, qa[i], qb[i],
                             mem[(12 + i) % 16], mem[(14 + i) % 16]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({tx_start_a, tx_start_b, load_done_a, load_done_b, send_done_a, send_done_b,
             busy_tx_a, busy_tx_b, rx_overrun_a, rx_overrun_b} !== 10'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0", {tx_start_a, tx_start_b, load_done_a,
                     load_done_b, send_done_a, send_done_b, busy_tx_a, busy_tx_b, rx_overrun_a, rx_overrun_b});
        end
        checks++;
        if (tx_byte_a !== 8'h00 || tx_byte_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_byte: got %h/%h want 00", tx_byte_a, tx_byte_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rx_load();
        rx_frame(1'b1);
        host_addr = 4'd3;
        tick();
        checks++;
        if (host_rdata_a !== 8'h13 || host_rdata_b !== 8'h13) begin
            failures++;
            $display("FAIL host_read_addr3: got %h/%h want 13", host_rdata_a, host_rdata_b);
        end
        read_back(0, 7);
    endtask

    task automatic test_host_write();
        for (int i = 0; i < 16; i++) begin
            host_addr  = 4'(i);
            host_wdata = 8'($urandom);
            host_we    = 1'b1;
            mem[i]     = host_wdata;
            tick();
        end
        host_we = 1'b0;
        read_back(0, 15);
    endtask

    task automatic test_tx();
        qa.delete();
        qb.delete();
        pulse_go();
        checks++;
        if ({busy_tx_a, busy_tx_b, send_done_a, send_done_b} !== 4'b1100) begin
            failures++;
            $display("FAIL tx_go_busy: got busy=%b%b send=%b%b want busy=11 send=00",
                     busy_tx_a, busy_tx_b, send_done_a, send_done_b);
        end
        wait_send_and_check("tx");
    endtask

    task automatic test_back_to_back();
        qa.delete();
        qb.delete();
        pulse_go();
        checks++;
        if ({send_done_a, send_done_b, busy_tx_a, busy_tx_b} !== 4'b0011) begin
            failures++;
            $display("FAIL resend_start: got send=%b%b busy=%b%b want send=00 busy=11",
                     send_done_a, send_done_b, busy_tx_a, busy_tx_b);
        end
        wait_send_and_check("resend");
    endtask

    task automatic test_ignored_inputs();
        // in S_DONE: a UART byte is dropped and flagged, not written anywhere
        send_byte(8'($urandom));
        checks++;
        if ({rx_overrun_a, rx_overrun_b} !== 2'b11) begin
            failures++;
            $display("FAIL overrun_set: got %b want 11", {rx_overrun_a, rx_overrun_b});
        end
        host_addr  = 4'd5;
        host_wdata = ~mem[5];
        host_we    = 1'b1;
        tick();
        host_we = 1'b0;
        read_back(0, 15);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if ({rx_overrun_a, rx_overrun_b, load_done_a, load_done_b, send_done_a, send_done_b} !== 6'b0) begin
            failures++;
            $display("FAIL restart_clear: got %b want 000000", {rx_overrun_a, rx_overrun_b,
                     load_done_a, load_done_b, send_done_a, send_done_b});
        end
        pulse_go();
        checks++;
        if ({busy_tx_a, busy_tx_b} !== 2'b00) begin
            failures++;
            $display("FAIL tx_go_in_rx: got busy=%b%b want 00", busy_tx_a, busy_tx_b);
        end
        host_addr  = 4'd10;
        host_wdata = ~mem[10];
        host_we    = 1'b1;
        tick();
        host_we = 1'b0;
        rx_frame(1'b0);
        read_back(0, 15);
    endtask

    task automatic test_restart_tx();
        int n = 0;
        qa.delete();
        qb.delete();
        pulse_go();
        while (qa.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL restart_tx_timeout: got %0d bytes want 2", qa.size());
        end
        tick();
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'($urandom);
        tick();
        restart  = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if ({rx_overrun_a, rx_overrun_b, busy_tx_a, busy_tx_b, load_done_a, load_done_b,
             tx_start_a, tx_start_b} !== 8'b0) begin
            failures++;
            $display("FAIL restart_in_tx: got %b want 00000000", {rx_overrun_a, rx_overrun_b,
                     busy_tx_a, busy_tx_b, load_done_a, load_done_b, tx_start_a, tx_start_b});
        end
        repeat (20) tick();
        checks++;
        if (qa.size() != 2 || qb.size() != 2) begin
            failures++;
            $display("FAIL restart_no_more_tx: got %0d/%0d want 2", qa.size(), qb.size());
        end
        rx_frame(1'b0);
        read_back(0, 7);
    endtask

    task automatic test_rst_mid_rx();
        logic [7:0] b;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_byte(b);
            mem[i] = b;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({tx_start_a, tx_start_b, load_done_a, load_done_b, send_done_a, send_done_b,
             busy_tx_a, busy_tx_b, rx_overrun_a, rx_overrun_b} !== 10'b0 ||
            tx_byte_a !== 8'h00 || tx_byte_b !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_rx: got flags=%b tx_byte=%h/%h want 0", {tx_start_a, tx_start_b,
                     load_done_a, load_done_b, send_done_a, send_done_b, busy_tx_a, busy_tx_b,
                     rx_overrun_a, rx_overrun_b}, tx_byte_a, tx_byte_b);
        end
        rx_frame(1'b0);
        read_back(0, 7);
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        host_we    = 1'b0;
        host_wdata = 8'h00;
        host_addr  = 4'd0;
        tx_go      = 1'b0;
        restart    = 1'b0;
        test_reset();
        test_rx_load();
        test_host_write();
        test_tx();
        test_back_to_back();
        test_ignored_inputs();
        test_restart_tx();
        test_rst_mid_rx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
